vfu_done_arbiter: RTL and testbench

- Collects per-VFU completion events (done + instruction ID) from the lane array.
- Serialises them through a round-robin arbiter into a small FIFO.
- Presents one completion per cycle to the instruction launcher over a valid/ready handshake.
- Sits between the lanes' vfus_done/vfus_done_id/vfus_done_gnt interface and the launcher's completion/retire logic.

---
 rtl/vfu_done_arbiter.sv | 138 +++++++++++++
 tb/tb_vfu_done_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vfu_done_arbiter.sv
// -----------------------------------------------------------------------------
// vfu_done_arbiter
//
// Collects completion events from the VFUs of the lane array, picks one per
// cycle with a round-robin arbiter, buffers it in a small FIFO and presents
// the oldest completion to the instruction launcher over valid/ready.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          asynchronous, active-high reset
//   req_done_i     per-VFU done request, held high by the VFU until granted
//   req_id_i       per-VFU instruction ID, packed NrReq x IdWidth
//   req_gnt_o      one-hot grant, combinational, in the cycle of acceptance
//   done_valid_o   FIFO head holds a completion
//   done_id_o      instruction ID of the head entry
//   done_src_o     VFU index that produced the head entry
//   done_ready_i   launcher accepts the head entry
//   fifo_count_o   current FIFO occupancy
// -----------------------------------------------------------------------------
module vfu_done_arbiter #(
    parameter  int NrReq     = 4,
    parameter  int IdWidth   = 3,
    parameter  int FifoDepth = 4,
    localparam int SrcW      = (NrReq > 1) ? $clog2(NrReq) : 1,
    localparam int PtrW      = (FifoDepth > 1) ? $clog2(FifoDepth) : 1,
    localparam int CntW      = $clog2(FifoDepth + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NrReq-1:0]         req_done_i,
    input  logic [NrReq*IdWidth-1:0] req_id_i,
    output logic [NrReq-1:0]         req_gnt_o,
    output logic                     done_valid_o,
    output logic [IdWidth-1:0]       done_id_o,
    output logic [SrcW-1:0]          done_src_o,
    input  logic                     done_ready_i,
    output logic [CntW-1:0]          fifo_count_o
);

    // Control state
    logic [SrcW-1:0]    r_rr_ptr;
    logic [PtrW-1:0]    r_wr_ptr;
    logic [PtrW-1:0]    r_rd_ptr;
    logic [CntW-1:0]    r_count;

    // Completion storage
    logic [IdWidth-1:0] r_mem_id  [FifoDepth];
    logic [SrcW-1:0]    r_mem_src [FifoDepth];

    logic [IdWidth-1:0] w_req_id [NrReq];
    logic               w_pop;
    logic               w_can_push;
    logic               w_gnt_any;
    logic [SrcW-1:0]    w_gnt_idx;
    logic [NrReq-1:0]   w_gnt;

    // Round-robin successor of the granted index, wrapping at NrReq (which
    // need not be a power of two).
    function automatic logic [SrcW-1:0] rr_next(input logic [SrcW-1:0] k);
        if (int'(k) == NrReq - 1) begin
            return '0;
        end
        return k + SrcW'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < NrReq; i++) begin
            w_req_id[i] = req_id_i[i*IdWidth +: IdWidth];
        end
    end

    assign done_valid_o = (r_count != '0);
    assign w_pop        = done_valid_o && done_ready_i;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts
    // when the launcher drains it. Nothing is accepted while in reset.
    assign w_can_push = !rst_i && ((r_count < CntW'(FifoDepth)) || w_pop);

    // Rotating priority search starting at r_rr_ptr; first requester wins.
    always_comb begin
        logic [SrcW:0] v_sum;
        logic [SrcW-1:0] v_sel;
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_gnt_any = 1'b0;
        v_sum     = '0;
        v_sel     = '0;
        for (int i = 0; i < NrReq; i++) begin
            v_sum = {1'b0, r_rr_ptr} + (SrcW+1)'(i);
            if (v_sum >= (SrcW+1)'(NrReq)) begin
                v_sum = v_sum - (SrcW+1)'(NrReq);
            end
            v_sel = v_sum[SrcW-1:0];
            if (w_can_push && !w_gnt_any && req_done_i[v_sel]) begin
                w_gnt_any    = 1'b1;
                w_gnt_idx    = v_sel;
                w_gnt[v_sel] = 1'b1;
            end
        end
    end

    assign req_gnt_o = w_gnt;

    // Grant/push stage: arbiter state, FIFO pointers, occupancy, storage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FifoDepth; i++) begin
                r_mem_id[i]  <= '0;
                r_mem_src[i] <= '0;
            end
        end else begin
            if (w_gnt_any) begin
                r_mem_id[r_wr_ptr]  <= w_req_id[w_gnt_idx];
                r_mem_src[r_wr_ptr] <= w_gnt_idx;
                r_wr_ptr            <= r_wr_ptr + PtrW'(1);
                r_rr_ptr            <= rr_next(w_gnt_idx);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            case ({w_gnt_any, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head entry straight from storage; no bypass from the request side.
    assign done_id_o    = r_mem_id[r_rd_ptr];
    assign done_src_o   = r_mem_src[r_rd_ptr];
    assign fifo_count_o = r_count;

endmodule

// File: tb/tb_vfu_done_arbiter.sv
module tb_vfu_done_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [11:0] req_id = '0;
    logic [3:0]  gnt;
    logic        dv;
    logic [2:0]  did;
    logic [1:0]  dsrc;
    logic        rdy = 1'b0;
    logic [2:0]  cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vfu_done_arbiter #(
        .NrReq     (4),
        .IdWidth   (3),
        .FifoDepth (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_done_i   (req),
        .req_id_i     (req_id),
        .req_gnt_o    (gnt),
        .done_valid_o (dv),
        .done_id_o    (did),
        .done_src_o   (dsrc),
        .done_ready_i (rdy),
        .fifo_count_o (cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input int k, input logic [2:0] v);
        req_id[k*3 +: 3] = v;
    endtask

    // Asserts reset asynchronously with all VFUs requesting and checks that
    // nothing is granted or visible; releases just after the next edge.
    task automatic do_reset();
        rst = 1'b1;
        req = 4'b1111;
        rdy = 1'b1;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_valid", dv, 0);
        chk("rst_cnt", cnt, 0);
        req = '0;
        rdy = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Protocol and invariant monitor
    logic [3:0] p_req = '0;
    logic [3:0] p_gnt = '0;
    logic       p_rst = 1'b1;
    always @(negedge clk) begin
        if (!rst) begin
            chk("a_onehot0", $onehot0(gnt), 1);
            chk("a_gnt_req", gnt & ~req, 0);
            chk("a_cnt_max", (cnt <= 3'd4), 1);
            if (!p_rst) chk("a_req_drop", p_req & ~p_gnt & ~req, 0);
        end
        p_req <= req;
        p_gnt <= gnt;
        p_rst <= rst;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] q[$];
        logic [3:0] exp_gnt;
        logic       exp_can;
        int j, cyc, dut_pops;

        // 1. reset then idle
        do_reset();
        rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("t1_idle", {gnt, dv, did, dsrc, cnt}, 0);
            tick();
        end

        // 2. single request, latency and pointer advance
        do_reset();
        rdy = 1'b1;
        req = 4'b0100;
        set_id(2, 3'd5);
        #1;
        chk("t2_gnt0", gnt, 4'b0100);
        chk("t2_valid0", dv, 0);
        tick();
        req = 4'b1001;
        set_id(3, 3'd6);
        set_id(0, 3'd7);
        #1;
        chk("t2_valid1", dv, 1);
        chk("t2_id1", did, 5);
        chk("t2_src1", dsrc, 2);
        chk("t2_cnt1", cnt, 1);
        chk("t2_ptr3", gnt, 4'b1000);
        tick();
        req = 4'b0001;
        #1;
        chk("t2_gnt2", gnt, 4'b0001);
        chk("t2_id2", did, 6);
        chk("t2_src2", dsrc, 3);
        chk("t2_cnt2", cnt, 1);
        tick();
        req = 4'b0000;
        #1;
        chk("t2_valid3", dv, 1);
        chk("t2_id3", did, 7);
        chk("t2_src3", dsrc, 0);
        tick();
        #1;
        chk("t2_empty", {dv, cnt}, 0);
        tick();
        #1;
        chk("t2_no_underflow", cnt, 0);

        // 3. round robin with all requesting
        do_reset();
        for (int k = 0; k < 4; k++) set_id(k, 3'(k + 1));
        req = 4'b1111;
        rdy = 1'b1;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk("t3_gnt", gnt, 4'b0001 << (k % 4));
            if (k == 0) begin
                chk("t3_valid0", dv, 0);
            end else begin
                chk("t3_valid", dv, 1);
                chk("t3_src", dsrc, (k - 1) % 4);
                chk("t3_id", did, (k - 1) % 4 + 1);
                chk("t3_cnt", cnt, 1);
            end
            tick();
        end

        // 4. full FIFO and backpressure
        do_reset();
        for (int k = 0; k < 4; k++) set_id(k, 3'(k + 1));
        req = 4'b1111;
        rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t4_fill_gnt", gnt, 4'b0001 << k);
            chk("t4_fill_cnt", cnt, k);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t4_full_gnt", gnt, 0);
            chk("t4_full_cnt", cnt, 4);
            chk("t4_full_head", {dv, did, dsrc}, {1'b1, 3'd1, 2'd0});
            tick();
        end
        rdy = 1'b1;
        #1;
        chk("t4_pp_gnt", gnt, 4'b0001);
        chk("t4_pp_cnt", cnt, 4);
        tick();
        rdy = 1'b0;
        #1;
        chk("t4_after_cnt", cnt, 4);
        chk("t4_after_head", {did, dsrc}, {3'd2, 2'd1});
        chk("t4_after_gnt", gnt, 0);
        tick();
        #1;
        chk("t4_hold_head", {did, dsrc}, {3'd2, 2'd1});
        rdy = 1'b1;
        #1;
        chk("t4_pp2_gnt", gnt, 4'b0010);
        tick();
        #1;
        chk("t4_order", {did, dsrc, cnt}, {3'd3, 2'd2, 3'd4});

        // 5. wrap-around with alternating ready against a queue model
        do_reset();
        j = 0;
        cyc = 0;
        dut_pops = 0;
        q.delete();
        while ((j < 10 || q.size() != 0) && cyc < 60) begin
            rdy = (cyc % 2 == 1);
            req = (j < 10) ? (4'b0001 << (j % 4)) : 4'b0000;
            if (j < 10) set_id(j % 4, 3'((j * 3 + 1) % 8));
            #1;
            exp_can = (q.size() < 4) || (q.size() > 0 && rdy);
            exp_gnt = (j < 10 && exp_can) ? (4'b0001 << (j % 4)) : 4'b0000;
            chk("t5_gnt", gnt, exp_gnt);
            chk("t5_valid", dv, q.size() != 0);
            chk("t5_cnt", cnt, q.size());
            if (q.size() != 0) chk("t5_head", {did, dsrc}, q[0]);
            if (dv && rdy) dut_pops++;
            if (q.size() != 0 && rdy) void'(q.pop_front());
            if (exp_gnt != 0) begin
                q.push_back({3'((j * 3 + 1) % 8), 2'(j % 4)});
                j++;
            end
            tick();
            cyc++;
        end
        chk("t5_timeout", (cyc < 60), 1);
        chk("t5_pops", dut_pops, 10);

        // 6. reset mid-operation
        do_reset();
        for (int k = 0; k < 4; k++) set_id(k, 3'(k + 1));
        rdy = 1'b0;
        req = 4'b1111;
        #1;
        chk("t6_gnt0", gnt, 4'b0001);
        tick();
        req = 4'b1110;
        #1;
        chk("t6_gnt1", gnt, 4'b0010);
        tick();
        req = 4'b1100;
        #1;
        chk("t6_gnt2", gnt, 4'b0100);
        tick();
        req = 4'b1011;
        #1;
        chk("t6_cnt3", cnt, 3);
        chk("t6_valid3", dv, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", dv, 0);
        chk("t6_rst_cnt", cnt, 0);
        chk("t6_rst_gnt", gnt, 0);
        tick();
        rst = 1'b0;
        rdy = 1'b1;
        #1;
        chk("t6_regnt0", gnt, 4'b0001);
        tick();
        req = 4'b1010;
        #1;
        chk("t6_regnt1", gnt, 4'b0010);
        chk("t6_head1", {dv, did, dsrc}, {1'b1, 3'd1, 2'd0});
        tick();
        req = 4'b1000;
        #1;
        chk("t6_regnt3", gnt, 4'b1000);
        tick();
        req = 4'b0000;
        #1;
        chk("t6_head3", {dv, did, dsrc}, {1'b1, 3'd4, 2'd3});
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
